// File: rtl/aes_req_arbiter.sv
// Two-requester arbiter that shares one AES core: round-robin grant, latch, start, capture.
// Optional WAIT-state timeout abort is compiled in with `define AES_ARB_TIMEOUT_EN.
module aes_req_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic         ACLK,
    input  logic         ARSTn,
    input  logic [1:0]   req_i,
    input  logic [255:0] data_i,
    input  logic [1:0]   dec_i,
    input  logic         expanding,
    input  logic         valid_AES,
    input  logic [127:0] busAES,
    output logic         start_AES,
    output logic         decrypt,
    output logic [127:0] busB,
    output logic [1:0]   done_o,
    output logic [127:0] result_o,
    output logic         busy_o,
    output logic         err_o
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e       state_q, state_d;
    logic         owner_q, owner_d;
    logic         ptr_q, ptr_d;
    logic         decrypt_q, decrypt_d;
    logic [127:0] busb_q, busb_d;
    logic [127:0] result_q, result_d;
    logic         winner;
    logic         timeout_hit;

    // Contention goes to the round-robin pointer; otherwise the lone requester wins.
    assign winner = (req_i == 2'b11) ? ptr_q : req_i[1];

`ifdef AES_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StIssue) begin
            cnt_d = '0;
        end else if (state_q == StWait) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Current WAIT cycle is the last one allowed.
    assign timeout_hit = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
    assign err_d       = (state_q == StWait) && !valid_AES && timeout_hit;
    assign err_o       = err_q;

    always_ff @(posedge ACLK or negedge ARSTn) begin
        if (!ARSTn) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_o       = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        decrypt_d = decrypt_q;
        busb_d    = busb_q;
        result_d  = result_q;
        unique case (state_q)
            StIdle: begin
                if ((|req_i) && !expanding) begin
                    owner_d   = winner;
                    busb_d    = winner ? data_i[255:128] : data_i[127:0];
                    decrypt_d = dec_i[winner];
                    state_d   = StIssue;
                end
            end
            StIssue: state_d = StWait;
            StWait: begin
                if (valid_AES) begin
                    result_d = busAES;
                    ptr_d    = ~owner_q;
                    state_d  = StDone;
                end else if (timeout_hit) begin
                    ptr_d   = ~owner_q;
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARSTn) begin
        if (!ARSTn) begin
            state_q   <= StIdle;
            owner_q   <= 1'b0;
            ptr_q     <= 1'b0;
            decrypt_q <= 1'b0;
            busb_q    <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            decrypt_q <= decrypt_d;
            busb_q    <= busb_d;
            result_q  <= result_d;
        end
    end

    assign start_AES = (state_q == StIssue);
    assign busy_o    = (state_q != StIdle);
    assign done_o    = (state_q == StDone) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign decrypt   = decrypt_q;
    assign busB      = busb_q;
    assign result_o  = result_q;

endmodule

// File: doc/aes_req_arbiter.md
AES_REQ_ARBITER -- requirements
Module: aes_req_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, maximum WAIT-state cycles before abort (used only with AES_ARB_TIMEOUT_EN).
REQ-002 ACLK  input  1  clock; all state changes on rising edge.
REQ-003 ARSTn  input  1  asynchronous active-low reset.
REQ-004 req_i  input  2  level request per requester; held until matching done_o pulse.
REQ-005 data_i  input  256  requester block data; [127:0] requester 0, [255:128] requester 1; stable while req_i high.
REQ-006 dec_i  input  2  per-requester decrypt select (1 = decrypt).
REQ-007 expanding  input  1  AES core key expansion in progress.
REQ-008 valid_AES  input  1  AES core result valid strobe.
REQ-009 busAES  input  128  AES core result bus.
REQ-010 start_AES  output  1  one-cycle start pulse to AES core.
REQ-011 decrypt  output  1  latched decrypt select of current owner.
REQ-012 busB  output  128  latched block data of current owner.
REQ-013 done_o  output  2  one-cycle completion pulse to owner.
REQ-014 result_o  output  128  last captured result.
REQ-015 busy_o  output  1  high in every state except IDLE.
REQ-016 err_o  output  1  timeout abort flag, pulsed with done_o.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT, DONE; encoding free.
REQ-018 IDLE: if any req_i high and expanding low, grant winner, latch data/dec into busB/decrypt, record owner, go to ISSUE; otherwise stay.
REQ-019 Arbitration: single request wins; both high -> requester indicated by round-robin pointer wins.
REQ-020 Pointer resets to 0; on entering DONE it points to the requester that did not own the completed job.
REQ-021 ISSUE: start_AES high for exactly this one cycle; next state WAIT.
REQ-022 WAIT: on valid_AES high, capture busAES into result_o, go to DONE; else stay.
REQ-023 DONE: done_o[owner] high for exactly this cycle; req_i not sampled; next state IDLE.
REQ-024 Latency: req_i sampled at edge N -> start_AES high in cycle N+1; valid_AES at edge M -> done_o high in cycle M+1.
REQ-025 busB and decrypt hold latched values from grant through DONE; change only on next grant.
REQ-026 valid_AES outside WAIT is ignored; result_o unchanged.
REQ-027 req_i change or drop by the owner during ISSUE/WAIT does not abort the job.
REQ-028 expanding high in IDLE blocks grants; expanding in other states is ignored.
REQ-029 result_o holds value until next capture; never cleared except by reset.

Reset
REQ-030 ARSTn low forces IDLE immediately, including mid-job; no done_o for the aborted job.
REQ-031 Reset values: start_AES 0, decrypt 0, busB 0, done_o 0, result_o 0, busy_o 0, err_o 0, pointer 0, timeout counter 0.

Configuration
REQ-032 Macro AES_ARB_TIMEOUT_EN defined: counter clears on entering WAIT, increments per WAIT cycle; reaching TIMEOUT_CYCLES without valid_AES -> DONE with done_o[owner] and err_o high one cycle, result_o unchanged.
REQ-033 Macro AES_ARB_TIMEOUT_EN undefined: no counter, WAIT indefinite, err_o tied 0.

Verification
REQ-034 req_i=01, data 0x00112233445566778899AABBCCDDEEFF, dec 0 -> start_AES one cycle after sample, busB equals data, decrypt 0; valid_AES with busAES 0x69C4E0D86A7B0430D8CDB78070B4C55A -> done_o=01 next cycle, result_o equals it.
REQ-035 req_i=11 from reset, repeated back-to-back -> grant order 0,1,0,1; done_o never 11.
REQ-036 expanding high 10 cycles with req_i=10 -> no start_AES; first start_AES one cycle after expanding falls.
REQ-037 Spurious valid_AES in IDLE with busAES 0xFF..FF -> result_o and done_o unchanged.
REQ-038 ARSTn low during WAIT -> all outputs at reset values, no done_o; pending req_i re-granted after release.
REQ-039 With AES_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, no valid_AES -> done_o and err_o pulse after 8 WAIT cycles; without macro, stays busy.
